icache_line: RTL and testbench

Direct-mapped, line-based instruction cache that sits between instruction fetch and the memory controller. It generalises the per-halfword cache to multi-halfword lines, with parametrised depth and line size. It adds its own refill state machine that fetches a whole line as a burst of 32-bit words, and it resolves 32-bit instructions that straddle two lines. Lookup is combinational; refill is sequential and one-request-at-a-time.

---
 rtl/icache_line.sv | 160 ++++++++++++++++
 tb/tb_icache_line.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_line.sv
// icache_line: direct-mapped line I-cache with burst refill FSM; ICACHE_FENCE_I_EN adds fence_i_in
module icache_line #(
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 3,
  parameter int ADDR_WIDTH   = 17
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        need_flush_in,
`ifdef ICACHE_FENCE_I_EN
  input  logic        fence_i_in,
`endif
  input  logic        if_valid,
  input  logic [31:0] if_instr_addr,
  output logic        hit_out,
  output logic        is_c_out,
  output logic [31:0] instr_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_ready_in,
  input  logic        mem_valid_in,
  input  logic [31:0] mem_data_in,
  output logic        busy_out
);
  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam int HWS   = 1 << OFFSET_WIDTH;
  localparam int WORDS = 1 << (OFFSET_WIDTH - 1);
  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH - 1;
  localparam int LO    = OFFSET_WIDTH + 1;
  localparam int HI    = INDEX_WIDTH + OFFSET_WIDTH;

  typedef enum logic [1:0] {IDLE, REFILL, DRAIN} state_e;

  state_e                  state_q;
  logic [DEPTH-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q [DEPTH];
  logic [15:0]             data_q [DEPTH][HWS];
  logic                    mem_req_q, busy_q, pend_q;
  logic [31:0]             mem_addr_q;
  logic [OFFSET_WIDTH-1:0] cnt_q;
  logic [INDEX_WIDTH-1:0]  ridx_q;

  logic [31:0]             a0, a1, miss_addr;
  logic [INDEX_WIDTH-1:0]  idx0, idx1, miss_idx;
  logic [OFFSET_WIDTH-1:0] off0, off1, hw_lo, hw_hi;
  logic [TAG_W-1:0]        tag0, tag1, miss_tag;
  logic [15:0]             hw0, hw1;
  logic                    hit0, hit1, need1, flush, start, last, unused_ok;

`ifdef ICACHE_FENCE_I_EN
  logic fence;
  assign fence = fence_i_in;
`else
  logic fence;
  assign fence = 1'b0;
`endif
  assign flush        = need_flush_in | fence;
  assign unused_ok    = if_instr_addr[0];
  assign mem_req_out  = mem_req_q;
  assign mem_addr_out = mem_addr_q;
  assign busy_out     = busy_q;

  // combinational lookup of hw0 and, for 32-bit instructions, hw1 (possibly in the next line)
  always_comb begin
    a0        = {if_instr_addr[31:1], 1'b0};
    a1        = a0 + 32'd2;
    idx0      = a0[HI:LO];
    idx1      = a1[HI:LO];
    off0      = a0[OFFSET_WIDTH:1];
    off1      = a1[OFFSET_WIDTH:1];
    tag0      = a0[ADDR_WIDTH-1:HI+1];
    tag1      = a1[ADDR_WIDTH-1:HI+1];
    hw0       = data_q[idx0][off0];
    hw1       = data_q[idx1][off1];
    hit0      = valid_q[idx0] && tag_q[idx0] == tag0;
    hit1      = valid_q[idx1] && tag_q[idx1] == tag1;
    need1     = hw0[1:0] == 2'b11;
    hit_out   = if_valid && hit0 && (!need1 || hit1);
    is_c_out  = hit_out && !need1;
    instr_out = !hit_out ? 32'd0 : need1 ? {hw1, hw0} : {16'd0, hw0};
    miss_addr = hit0 ? a1 : a0;
    miss_idx  = hit0 ? idx1 : idx0;
    miss_tag  = hit0 ? tag1 : tag0;
    start     = state_q == IDLE && if_valid && !hit_out && !flush;
    hw_lo     = cnt_q << 1;
    hw_hi     = hw_lo | OFFSET_WIDTH'(1);
    last      = cnt_q == OFFSET_WIDTH'(WORDS - 1);
  end

  // refill FSM: one outstanding word request at a time, flush drains an unanswered request
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      ridx_q     <= '0;
    end else if (rdy_in) begin
      case (state_q)
        IDLE: if (start) begin
          state_q           <= REFILL;
          busy_q            <= 1'b1;
          mem_req_q         <= 1'b1;
          mem_addr_q        <= miss_addr & ~((32'd1 << LO) - 32'd1);
          cnt_q             <= '0;
          pend_q            <= 1'b0;
          ridx_q            <= miss_idx;
          valid_q[miss_idx] <= 1'b0;
        end
        REFILL: if (flush) begin
          mem_req_q <= 1'b0;
          pend_q    <= 1'b0;
          cnt_q     <= '0;
          if ((pend_q || (mem_req_q && mem_ready_in)) && !mem_valid_in) state_q <= DRAIN;
          else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end else begin
          if (mem_req_q && mem_ready_in) begin
            mem_req_q <= 1'b0;
            pend_q    <= 1'b1;
          end
          if (mem_valid_in) begin
            pend_q <= 1'b0;
            cnt_q  <= last ? '0 : cnt_q + 1'b1;
            if (last) begin
              valid_q[ridx_q] <= 1'b1;
              state_q         <= IDLE;
              busy_q          <= 1'b0;
            end else begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= mem_addr_q + 32'd4;
            end
          end
        end
        default: if (mem_valid_in) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      if (fence) valid_q <= '0;
    end
  end

  // tag written when a refill starts, halfword pairs written as each response word arrives
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (start) tag_q[miss_idx] <= miss_tag;
      if (state_q == REFILL && !flush && mem_valid_in) begin
        data_q[ridx_q][hw_lo] <= mem_data_in[15:0];
        data_q[ridx_q][hw_hi] <= mem_data_in[31:16];
      end
    end
  end
endmodule

// File: tb/tb_icache_line.sv
// tb_icache_line: scoreboard bench for icache_line with a single-cycle-accept, latency-1 memory model
module tb_icache_line;
  logic        clk_in = 0, rst_in = 1, rdy_in = 1, need_flush_in = 0, if_valid = 0;
  logic        mem_ready_in = 0, mem_valid_in = 0;
  logic [31:0] if_instr_addr = 0, mem_data_in = 0;
`ifdef ICACHE_FENCE_I_EN
  logic        fence_i_in = 0;
`endif
  logic        hit_out, is_c_out, mem_req_out, busy_out;
  logic [31:0] instr_out, mem_addr_out;

  int          tests_run = 0, tests_failed = 0;
  logic [31:0] mem [1024];
  logic [31:0] exp_addr [$];
  logic [32:0] exp_res [$];
  bit          pend = 0, resp_en = 1;
  logic [9:0]  paddr = 0;

  icache_line dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .need_flush_in(need_flush_in),
`ifdef ICACHE_FENCE_I_EN
    .fence_i_in(fence_i_in),
`endif
    .if_valid(if_valid), .if_instr_addr(if_instr_addr),
    .hit_out(hit_out), .is_c_out(is_c_out), .instr_out(instr_out),
    .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
    .mem_ready_in(mem_ready_in), .mem_valid_in(mem_valid_in), .mem_data_in(mem_data_in),
    .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  // one clock cycle: memory accepts any request at once and answers one cycle later
  task automatic step();
    logic acc, gave;
    logic [31:0] a, e;
    mem_valid_in = pend && resp_en && rdy_in;
    mem_data_in  = mem_valid_in ? mem[paddr] : 32'd0;
    mem_ready_in = mem_req_out && rdy_in;
    acc  = mem_ready_in;
    gave = mem_valid_in;
    a    = mem_addr_out;
    @(posedge clk_in);
    #1;
    mem_valid_in = 0;
    mem_ready_in = 0;
    if (gave) pend = 0;
    if (acc) begin
      pend  = 1;
      paddr = a[11:2];
      tests_run++;
      if (exp_addr.size() == 0) begin
        tests_failed++;
        $display("FAIL mem_addr: unexpected request got %h expected none", a);
      end else begin
        e = exp_addr.pop_front();
        if (a !== e) begin
          tests_failed++;
          $display("FAIL mem_addr: got %h expected %h", a, e);
        end
      end
    end
  endtask

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_addr.push_back(base + 32'(4 * i));
  endtask

  task automatic do_reset();
    rst_in = 1;
    #3;
    rst_in = 0;
    pend = 0;
    resp_en = 1;
    exp_addr.delete();
  endtask

  // hold the lookup until it hits (bounded) and compare against the queued expectation
  task automatic do_lookup(input logic [31:0] a, input logic [31:0] ei, input bit ec, output int n);
    logic [32:0] e;
    exp_res.push_back({ec, ei});
    if_valid = 1;
    if_instr_addr = a;
    n = 0;
    #1;
    while (!hit_out && n < 100) begin
      step();
      n++;
    end
    e = exp_res.pop_front();
    tests_run++;
    if (!hit_out) begin
      tests_failed++;
      $display("FAIL lookup_timeout @%h: hit_out got 0 expected 1", a);
    end else if (instr_out !== e[31:0]) begin
      tests_failed++;
      $display("FAIL instr @%h: got %h expected %h", a, instr_out, e[31:0]);
    end
    tests_run++;
    if (is_c_out !== e[32]) begin
      tests_failed++;
      $display("FAIL is_c @%h: got %b expected %b", a, is_c_out, e[32]);
    end
    if_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    if_valid = 1;
    if_instr_addr = 32'h100;
    #1;
    tests_run++; if (hit_out !== 1'b0) begin tests_failed++; $display("FAIL reset_hit: got %b expected 0", hit_out); end
    tests_run++; if (instr_out !== 32'd0) begin tests_failed++; $display("FAIL reset_instr: got %h expected 0", instr_out); end
    tests_run++; if (mem_req_out !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b expected 0", mem_req_out); end
    tests_run++; if (mem_addr_out !== 32'd0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0", mem_addr_out); end
    tests_run++; if (busy_out !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
    if_valid = 0;
  endtask

  task automatic test_cold_miss();
    int n;
    push_line(32'h100);
    do_lookup(32'h100, 32'h0000_0013, 0, n);
    tests_run++; if (n != 9) begin tests_failed++; $display("FAIL cold_latency: got %0d expected 9", n); end
    tests_run++; if (exp_addr.size() != 0) begin tests_failed++; $display("FAIL cold_reqs_left: got %0d expected 0", exp_addr.size()); end
  endtask

  task automatic test_compressed();
    int n;
    do_reset();
    mem[32'h40] = 32'h4501_0013;
    push_line(32'h100);
    do_lookup(32'h102, 32'h0000_4501, 1, n);
    do_lookup(32'h100, 32'h4501_0013, 0, n);
    tests_run++; if (n != 0) begin tests_failed++; $display("FAIL hit_latency: got %0d expected 0", n); end
  endtask

  task automatic test_straddle();
    int n;
    push_line(32'h110);
    do_lookup(32'h10E, 32'h4413_0503, 0, n);
    tests_run++; if (n != 9) begin tests_failed++; $display("FAIL straddle_latency: got %0d expected 9", n); end
    push_line(32'h3F0);
    push_line(32'h400);
    do_lookup(32'h3FE, 32'h0013_00FF, 0, n);
    tests_run++; if (n != 18) begin tests_failed++; $display("FAIL wrap_latency: got %0d expected 18", n); end
  endtask

  task automatic test_flush_drain();
    do_reset();
    exp_addr.push_back(32'h100);
    exp_addr.push_back(32'h104);
    if_valid = 1;
    if_instr_addr = 32'h100;
    step();
    if_valid = 0;
    step();
    step();
    resp_en = 0;
    step();
    need_flush_in = 1;
    step();
    need_flush_in = 0;
    tests_run++; if (busy_out !== 1'b1) begin tests_failed++; $display("FAIL drain_busy: got %b expected 1", busy_out); end
    tests_run++; if (mem_req_out !== 1'b0) begin tests_failed++; $display("FAIL drain_req: got %b expected 0", mem_req_out); end
    resp_en = 1;
    step();
    tests_run++; if (busy_out !== 1'b0) begin tests_failed++; $display("FAIL drain_exit: got %b expected 0", busy_out); end
    if_valid = 1;
    #1;
    tests_run++; if (hit_out !== 1'b0) begin tests_failed++; $display("FAIL drain_line_invalid: got %b expected 0", hit_out); end
    if_valid = 0;
  endtask

  task automatic test_flush_valid();
    exp_addr.push_back(32'h500);
    if_valid = 1;
    if_instr_addr = 32'h500;
    step();
    if_valid = 0;
    step();
    need_flush_in = 1;
    step();
    need_flush_in = 0;
    tests_run++; if (busy_out !== 1'b0) begin tests_failed++; $display("FAIL flush_valid_idle: got %b expected 0", busy_out); end
    if_valid = 1;
    #1;
    tests_run++; if (hit_out !== 1'b0) begin tests_failed++; $display("FAIL flush_valid_line: got %b expected 0", hit_out); end
    if_valid = 0;
  endtask

  task automatic test_flush_idle();
    if_valid = 1;
    if_instr_addr = 32'h600;
    need_flush_in = 1;
    step();
    need_flush_in = 0;
    if_valid = 0;
    tests_run++; if (busy_out !== 1'b0) begin tests_failed++; $display("FAIL flush_idle_busy: got %b expected 0", busy_out); end
    tests_run++; if (mem_req_out !== 1'b0) begin tests_failed++; $display("FAIL flush_idle_req: got %b expected 0", mem_req_out); end
  endtask

  task automatic test_rdy_hold();
    int n;
    push_line(32'h200);
    if_valid = 1;
    if_instr_addr = 32'h200;
    step();
    if_valid = 0;
    step();
    step();
    rdy_in = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++; if (mem_addr_out !== 32'h204) begin tests_failed++; $display("FAIL hold_addr: got %h expected 00000204", mem_addr_out); end
      tests_run++; if (mem_req_out !== 1'b1) begin tests_failed++; $display("FAIL hold_req: got %b expected 1", mem_req_out); end
    end
    rdy_in = 1;
    do_lookup(32'h200, 32'h0080_8013, 0, n);
    do_lookup(32'h20C, 32'h0083_8313, 0, n);
    tests_run++; if (n != 0) begin tests_failed++; $display("FAIL hold_last_word: got %0d expected 0", n); end
  endtask

`ifdef ICACHE_FENCE_I_EN
  task automatic test_fence();
    int n;
    fence_i_in = 1;
    step();
    fence_i_in = 0;
    if_valid = 1;
    if_instr_addr = 32'h200;
    #1;
    tests_run++; if (hit_out !== 1'b0) begin tests_failed++; $display("FAIL fence_miss: got %b expected 0", hit_out); end
    push_line(32'h200);
    step();
    tests_run++; if (mem_req_out !== 1'b1) begin tests_failed++; $display("FAIL fence_req: got %b expected 1", mem_req_out); end
    do_lookup(32'h200, 32'h0080_8013, 0, n);
  endtask
`endif

  task automatic test_async_reset();
    if_valid = 1;
    if_instr_addr = 32'h700;
    step();
    if_valid = 0;
    #2;
    rst_in = 1;
    #1;
    tests_run++; if (mem_req_out !== 1'b0) begin tests_failed++; $display("FAIL areset_req: got %b expected 0", mem_req_out); end
    tests_run++; if (busy_out !== 1'b0) begin tests_failed++; $display("FAIL areset_busy: got %b expected 0", busy_out); end
    tests_run++; if (mem_addr_out !== 32'd0) begin tests_failed++; $display("FAIL areset_addr: got %h expected 0", mem_addr_out); end
    rst_in = 0;
    pend = 0;
    exp_addr.delete();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {i[15:0], i[7:0], 8'h13};
    mem[32'h40] = 32'h0000_0013;
    mem[32'h43] = 32'h0503_4313;
    test_reset();
    test_cold_miss();
    test_compressed();
    test_straddle();
    test_flush_drain();
    test_flush_valid();
    test_flush_idle();
    test_rdy_hold();
`ifdef ICACHE_FENCE_I_EN
    test_fence();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
